// File: rtl/max10_link_pkg.sv
// Shared constants and types for the MAX10 sync/tx status link.
// Used by the device-side responder and by the host reset-button poller.
package max10_link_pkg;

   localparam int FRAME_BITS_DEF  = 64;
   localparam int GAP_CYCLES_DEF  = 16;
   localparam int SYNC_STAGES_DEF = 2;

   // Host pacing in clk cycles; the low phase must cover the
   // synchronizer plus the tx update before the host samples.
   localparam int SYNC_HIGH_CLKS  = 2;
   localparam int SYNC_LOW_CLKS   = 4;
   localparam int HOST_GAP_CLKS   = 64;

   localparam int RESET_BIT_INDEX = 48;

   typedef enum logic [1:0] {
      ST_HUNT,
      ST_ARMED,
      ST_SHIFT,
      ST_DONE
   } link_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer with registered-level edge strobes.
// Ports: clk, rst_n, d_i (async in), level_o (synced), rise_o, fall_o.
module sync_edge_detect #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              dly_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         dly_q  <= sync_q[STAGES-1];
      end
   end

   assign level_o = sync_q[STAGES-1];
   assign rise_o  = sync_q[STAGES-1] & ~dly_q;
   assign fall_o  = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/max10_sync_responder.sv
// Device end of the MAX10 sync/tx link: returns status serially per sync pulse.
// Ports: clk, rst_n, sync, rx, status in; tx, frame_start, frame_done, overrun, rx_seen out.
module max10_sync_responder
   import max10_link_pkg::*;
#(
   parameter int   FRAME_BITS  = FRAME_BITS_DEF,
   parameter int   GAP_CYCLES  = GAP_CYCLES_DEF,
   parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
   parameter logic IDLE_LEVEL  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sync,
   input  logic                  rx,
   input  logic [FRAME_BITS-1:0] status,
   output logic                  tx,
   output logic                  frame_start,
   output logic                  frame_done,
   output logic                  overrun,
   output logic                  rx_seen
);

   localparam int IW = $clog2(FRAME_BITS);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BITS - 1);
   localparam logic [GW-1:0] GAP_SAT  = GW'(GAP_CYCLES);

   logic s_lvl, s_rise, s_fall;
   logic r_lvl, r_rise, r_fall;

   sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (sync),
      .level_o(s_lvl),
      .rise_o (s_rise),
      .fall_o (s_fall)
   );

   sync_edge_detect #(.STAGES(SYNC_STAGES)) u_rx (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (rx),
      .level_o(r_lvl),
      .rise_o (r_rise),
      .fall_o (r_fall)
   );

   // Any synchronized evidence of rx having been high.
   logic rx_hit;
   assign rx_hit = r_lvl | r_rise | r_fall;

   // Idle-gap counter: saturating run length of low sync samples.
   logic [GW-1:0] gap_q, gap_d;
   logic          gap_sat;

   always_comb begin
      gap_d = gap_q;
      if (s_lvl) begin
         gap_d = '0;
      end else if (gap_q != GAP_SAT) begin
         gap_d = gap_q + GW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) gap_q <= '0;
      else        gap_q <= gap_d;
   end

   assign gap_sat = (gap_q == GAP_SAT);

   link_state_e           state_q;
   logic [FRAME_BITS-1:0] shadow_q;
   logic [IW-1:0]         idx_q;
   logic [IW-1:0]         idx_nxt;
   logic                  tx_q;
   logic                  start_q;
   logic                  done_q;
   logic                  ovr_q;
   logic                  rxs_q;

   assign idx_nxt = idx_q + IW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_HUNT;
         shadow_q <= '1;
         idx_q    <= '0;
         tx_q     <= IDLE_LEVEL;
         start_q  <= 1'b0;
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
         rxs_q    <= 1'b0;
      end else begin
         start_q <= 1'b0;
         done_q  <= 1'b0;
         if (rx_hit) rxs_q <= 1'b1;

         // A saturated gap re-arms from every state except ARMED,
         // where it is the normal waiting condition.
         if (gap_sat && state_q != ST_ARMED) begin
            state_q  <= ST_ARMED;
            shadow_q <= status;
            idx_q    <= '0;
            tx_q     <= status[0];
            start_q  <= 1'b1;
         end else begin
            unique case (state_q)
               ST_HUNT: begin
                  tx_q <= IDLE_LEVEL;
               end
               ST_ARMED: begin
                  if (s_rise) state_q <= ST_SHIFT;
               end
               ST_SHIFT: begin
                  if (s_fall) begin
                     if (idx_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                        tx_q    <= IDLE_LEVEL;
                        done_q  <= 1'b1;
                        ovr_q   <= 1'b0;
                     end else begin
                        idx_q <= idx_nxt;
                        tx_q  <= shadow_q[idx_nxt];
                     end
                  end
               end
               ST_DONE: begin
                  tx_q <= IDLE_LEVEL;
                  if (s_rise) begin
                     ovr_q   <= 1'b1;
                     state_q <= ST_HUNT;
                  end
               end
            endcase
         end
      end
   end

   assign tx          = tx_q;
   assign frame_start = start_q;
   assign frame_done  = done_q;
   assign overrun     = ovr_q;
   assign rx_seen     = rxs_q;

endmodule
